memory_access_unit: RTL and testbench

Memory-stage load/store sequencer that consumes the execute stage's address (ALU result) and store data. It serialises one 48-bit scalar word or 6x8-bit vector into byte-wide accesses to a synchronous data memory, or gathers 6 bytes back into a 48-bit load result. It stalls the pipeline while busy, and its load result feeds writeback and the M-stage forward path.

---
 rtl/mem_access_pkg.sv | 47 ++++
 rtl/byte_lane_select.sv | 17 +
 rtl/memory_access_unit.sv | 145 ++++++++++++++
 tb/tb_memory_access_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage load/store sequencer.
//   - sizing constants (word, byte, lane count, address, counter widths)
//   - sequencer state encoding
//   - lane slice / lane insert helpers (lane i = bits [8i+7:8i])
package mem_access_pkg;

  localparam int DATA_WIDTH  = 48;
  localparam int BYTE_WIDTH  = 8;
  localparam int LANES       = DATA_WIDTH / BYTE_WIDTH;
  localparam int ADDR_WIDTH  = 16;
  localparam int COUNT_WIDTH = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RDRAIN,
    DONE
  } state_e;

  // Lane index is wider than needed (values LANES..2^COUNT_WIDTH-1 exist),
  // so select by compare rather than a variable part-select that could run
  // off the top of the word.
  function automatic logic [BYTE_WIDTH-1:0] lane_slice(
    input logic [DATA_WIDTH-1:0]  word,
    input logic [COUNT_WIDTH-1:0] idx
  );
    logic [BYTE_WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < LANES; i++)
      if (idx == COUNT_WIDTH'(i)) b = word[i*BYTE_WIDTH +: BYTE_WIDTH];
    return b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_insert(
    input logic [DATA_WIDTH-1:0]  word,
    input logic [COUNT_WIDTH-1:0] idx,
    input logic [BYTE_WIDTH-1:0]  b
  );
    logic [DATA_WIDTH-1:0] w;
    w = word;
    for (int i = 0; i < LANES; i++)
      if (idx == COUNT_WIDTH'(i)) w[i*BYTE_WIDTH +: BYTE_WIDTH] = b;
    return w;
  endfunction

endpackage

// File: rtl/byte_lane_select.sv
// Picks lane[sel_i] out of a packed 48-bit word (lane 0 = lowest byte).
// Used by the store path; also usable by a vector-load path.
// Ports:
//   word_i  packed word
//   sel_i   lane index
//   byte_o  selected lane (0 when sel_i is out of range)
module byte_lane_select
  import mem_access_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]  word_i,
  input  logic [COUNT_WIDTH-1:0] sel_i,
  output logic [BYTE_WIDTH-1:0]  byte_o
);

  assign byte_o = lane_slice(word_i, sel_i);

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage load/store sequencer. Serialises a 48-bit word (or one byte)
// into byte-wide accesses to a synchronous data memory, or gathers bytes
// back into a 48-bit load result. Little-endian: lane 0 at the base address.
//
// Optional build macro MEMACC_WRAP_ERR_EN: adds rsp_err and rejects accesses
// whose last byte would run past the top of the address space (no memory
// cycles, straight to DONE, rsp_rdata cleared). Without it addresses wrap.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   req_valid/req_ready     request handshake from execute stage
//   req_write, req_byte     store/load, single-byte/full-word
//   req_addr, req_wdata     base byte address, store data
//   stall                   freeze upstream while busy or a request is pending
//   mem_addr/mem_wdata      memory byte address / write byte
//   mem_we/mem_re/mem_rdata memory strobes; read data valid cycle after mem_re
//   rsp_valid, rsp_rdata    completion pulse, load result held until next one
//   rsp_err                 (MEMACC_WRAP_ERR_EN only) address-overflow flag
module memory_access_unit
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BYTE_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [BYTE_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
`ifdef MEMACC_WRAP_ERR_EN
  output logic                  rsp_err,
`endif
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] last_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;      // store data, or load gather buffer
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;

  logic [COUNT_WIDTH-1:0] req_last;
  logic [COUNT_WIDTH-1:0] cap_idx;
  logic [DATA_WIDTH-1:0]  data_cap_d;
  logic [BYTE_WIDTH-1:0]  lane_byte;
  logic                   active;

  assign req_last = req_byte ? '0 : COUNT_WIDTH'(LANES - 1);

  // Read data lags mem_re by one cycle, so the byte arriving now belongs to
  // the previous count (or to the last lane while draining).
  assign cap_idx    = (state_q == RDRAIN) ? last_q : cnt_q - COUNT_WIDTH'(1);
  assign data_cap_d = lane_insert(data_q, cap_idx, mem_rdata);

  byte_lane_select u_lane_sel (
    .word_i (data_q),
    .sel_i  (cnt_q),
    .byte_o (lane_byte)
  );

`ifdef MEMACC_WRAP_ERR_EN
  logic                  err_q;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  wrap_err;

  // Carry out of base+last means the access would cross the top address.
  assign end_addr = {1'b0, req_addr} + {{(ADDR_WIDTH+1-COUNT_WIDTH){1'b0}}, req_last};
  assign wrap_err = end_addr[ADDR_WIDTH];
  assign rsp_err  = err_q & (state_q == DONE);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_rdata_q <= '0;
`ifdef MEMACC_WRAP_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            last_q <= req_last;
            cnt_q  <= '0;
            // Loads start from zero so a byte load comes out zero-extended.
            data_q <= req_write ? req_wdata : '0;
`ifdef MEMACC_WRAP_ERR_EN
            if (wrap_err) begin
              err_q       <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= DONE;
            end else begin
              err_q   <= 1'b0;
              state_q <= req_write ? WRITE : READ;
            end
`else
            state_q <= req_write ? WRITE : READ;
`endif
          end
        end
        WRITE: begin
          if (cnt_q == last_q) state_q <= DONE;
          else                 cnt_q   <= cnt_q + COUNT_WIDTH'(1);
        end
        READ: begin
          if (cnt_q != '0) data_q <= data_cap_d;
          if (cnt_q == last_q) state_q <= RDRAIN;
          else                 cnt_q   <= cnt_q + COUNT_WIDTH'(1);
        end
        RDRAIN: begin
          // Final byte goes straight into the result so it is visible in DONE.
          data_q      <= data_cap_d;
          rsp_rdata_q <= data_cap_d;
          state_q     <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign active    = (state_q == WRITE) || (state_q == READ);
  assign req_ready = (state_q == IDLE);
  assign stall     = (state_q != IDLE) | req_valid;
  assign mem_we    = (state_q == WRITE);
  assign mem_re    = (state_q == READ);
  assign mem_addr  = active ? addr_q + {{(ADDR_WIDTH-COUNT_WIDTH){1'b0}}, cnt_q} : '0;
  assign mem_wdata = (state_q == WRITE) ? lane_byte : '0;
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a byte-wide synchronous memory
// model. Build with MEMACC_WRAP_ERR_EN defined to exercise the overflow flag.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_byte;
  logic [15:0] req_addr;
  logic [47:0] req_wdata;
  logic        req_ready, stall;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic        rsp_valid;
  logic [47:0] rsp_rdata;
`ifdef MEMACC_WRAP_ERR_EN
  logic        rsp_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mem [0:65535];
  logic       mem_clr;

  memory_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
`ifdef MEMACC_WRAP_ERR_EN
    .rsp_err   (rsp_err),
`endif
    .rsp_rdata (rsp_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One request, then cycle-by-cycle checks through T+lat+1.
  task automatic do_op(input string tag, input bit w, input bit b,
                       input logic [15:0] a, input logic [47:0] wd,
                       input int lat, input logic [47:0] exp_rd);
    int          n;
    logic [15:0] ea;
    logic [47:0] wtmp;
    n    = b ? 1 : 6;
    wtmp = wd;
    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1);
    req_valid = 1; req_write = w; req_byte = b; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      chk({tag, ".we"}, mem_we, (w && k <= n));
      chk({tag, ".re"}, mem_re, (!w && k <= n));
      if (k <= n) begin
        ea = a + 16'(k - 1);
        chk({tag, ".addr"}, mem_addr, ea);
        if (w) chk({tag, ".wdata"}, mem_wdata, wtmp[8*(k-1) +: 8]);
      end
      chk({tag, ".rsp_valid"}, rsp_valid, (k == lat));
      if (k == lat) chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int rv_seen;
    reset = 1; mem_clr = 1;
    req_valid = 0; req_write = 0; req_byte = 0; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;
    mem_clr = 0;
    @(negedge clk);
    chk("rst.ready", req_ready, 1);
    chk("rst.we",    mem_we, 0);
    chk("rst.re",    mem_re, 0);
    chk("rst.addr",  mem_addr, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.rsp",   rsp_valid, 0);
    chk("rst.rdata", rsp_rdata, 0);
    reset = 0;

    do_op("st_full",  1, 0, 16'h0010, 48'h060504030201, 7, 48'h0);
    do_op("ld_full",  0, 0, 16'h0010, 48'h0,            8, 48'h060504030201);
    do_op("ld_byte",  0, 1, 16'h0012, 48'h0,            3, 48'h000000000003);
    do_op("st_byte",  1, 1, 16'h0020, 48'h123456789AAB, 2, 48'h000000000003);
    do_op("ld_byte2", 0, 1, 16'h0020, 48'h0,            3, 48'h0000000000AB);

`ifdef MEMACC_WRAP_ERR_EN
    @(negedge clk);
    req_valid = 1; req_write = 1; req_byte = 0; req_addr = 16'hFFFE; req_wdata = 48'h0C0B0A090807;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    chk("wrap.we",    mem_we, 0);
    chk("wrap.rsp",   rsp_valid, 1);
    chk("wrap.err",   rsp_err, 1);
    chk("wrap.rdata", rsp_rdata, 0);
    @(negedge clk);
    chk("wrap.rsp_end", rsp_valid, 0);
    chk("wrap.err_end", rsp_err, 0);
    chk("wrap.ready",   req_ready, 1);
    chk("wrap.mem",     mem[16'hFFFE], 8'h00);
    do_op("byte_top", 1, 1, 16'hFFFF, 48'h0000000000EE, 2, 48'h0);
`else
    do_op("st_wrap", 1, 0, 16'hFFFE, 48'h0C0B0A090807, 7, 48'h0000000000AB);
    do_op("ld_wrap", 0, 0, 16'hFFFE, 48'h0,            8, 48'h0C0B0A090807);
`endif

    // Back-to-back: second store waits with req_valid held high.
    @(negedge clk);
    chk("b2b.ready0", req_ready, 1);
    req_valid = 1; req_write = 1; req_byte = 0; req_addr = 16'h0030; req_wdata = 48'h0F0E0D0C0B0A;
    @(posedge clk); #1;
    req_addr = 16'h0036; req_wdata = 48'h665544332211;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("b2b.stall", stall, 1);
      chk("b2b.ready", req_ready, (k == 8));
      chk("b2b.rspA",  rsp_valid, (k == 7));
    end
    @(posedge clk); #1;
    req_valid = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("b2b.B_addr",  mem_addr, 16'h0036);
        chk("b2b.B_wdata", mem_wdata, 8'h11);
      end
      chk("b2b.rspB", rsp_valid, (k == 7));
    end
    chk("b2b.memA", mem[16'h0035], 8'h0F);
    do_op("b2b.ldB", 0, 0, 16'h0036, 48'h0, 8, 48'h665544332211);

    // Async reset in the middle of a full store.
    @(negedge clk);
    req_valid = 1; req_write = 1; req_byte = 0; req_addr = 16'h0040; req_wdata = 48'h2D2C2B2A2928;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rmid.we_before", mem_we, 1);
    chk("rmid.addr_before", mem_addr, 16'h0043);
    reset = 1;
    #1;
    chk("rmid.we",    mem_we, 0);
    chk("rmid.ready", req_ready, 1);
    chk("rmid.addr",  mem_addr, 0);
    chk("rmid.rdata", rsp_rdata, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    rv_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
    end
    chk("rmid.no_rsp", rv_seen, 0);
    chk("rmid.mem42", mem[16'h0042], 8'h2A);
    chk("rmid.mem43", mem[16'h0043], 8'h00);
    do_op("rmid.ld", 0, 1, 16'h0041, 48'h0, 3, 48'h000000000029);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
